// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, immediate generation, register file read and
// writeback port, registered into the decode->execute pipeline register.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int CLEAR_REGS = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     instr_dc_i,
  input  logic [XLEN-1:0] pc_dc_i,
  input  logic [XLEN-1:0] pc_next_4_dc_i,
  input  logic            stall_dc_i,
  input  logic            flush_ex_i,
  input  logic            rd_wr_en_wb_i,
  input  logic [4:0]      rd_a_wb_i,
  input  logic [XLEN-1:0] rd_wd_wb_i,
  output logic [XLEN-1:0] rs1_d_ex_o,
  output logic [XLEN-1:0] rs2_d_ex_o,
  output logic [XLEN-1:0] imm_ex_o,
  output logic [4:0]      rs1_a_ex_o,
  output logic [4:0]      rs2_a_ex_o,
  output logic [4:0]      rd_a_ex_o,
  output logic [2:0]      funct3_ex_o,
  output logic [3:0]      alu_op_ex_o,
  output logic            alu_src_ex_o,
  output logic            alu_a_pc_ex_o,
  output logic            reg_wr_en_ex_o,
  output logic            mem_rd_en_ex_o,
  output logic            mem_wr_en_ex_o,
  output logic [1:0]      result_src_ex_o,
  output logic            branch_ex_o,
  output logic            jump_ex_o,
  output logic            jalr_ex_o,
  output logic            illegal_ex_o,
  output logic [XLEN-1:0] pc_ex_o,
  output logic [XLEN-1:0] pc_next_4_ex_o
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] rs1_d;
    logic [XLEN-1:0] rs2_d;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1_a;
    logic [4:0]      rs2_a;
    logic [4:0]      rd_a;
    logic [2:0]      funct3;
    alu_op_e         alu_op;
    logic            alu_src;
    logic            alu_a_pc;
    logic            reg_wr_en;
    logic            mem_rd_en;
    logic            mem_wr_en;
    logic [1:0]      result_src;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            illegal;
  } ex_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_a;
  logic [4:0] rs2_a;
  logic [4:0] rd_a;

  assign opcode = instr_dc_i[6:0];
  assign funct3 = instr_dc_i[14:12];
  assign funct7 = instr_dc_i[31:25];
  assign rs1_a  = instr_dc_i[19:15];
  assign rs2_a  = instr_dc_i[24:20];
  assign rd_a   = instr_dc_i[11:7];

  alu_op_e   alu_op;
  imm_sel_e  imm_sel;
  logic      alu_src;
  logic      alu_a_pc;
  logic      reg_wr_en;
  logic      mem_rd_en;
  logic      mem_wr_en;
  logic [1:0] result_src;
  logic      branch;
  logic      jump;
  logic      jalr;
  logic      illegal;

  always_comb begin
    alu_op     = ALU_ADD;
    imm_sel    = IMM_NONE;
    alu_src    = 1'b0;
    alu_a_pc   = 1'b0;
    reg_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    result_src = 2'd0;
    branch     = 1'b0;
    jump       = 1'b0;
    jalr       = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_LUI: begin
        alu_op    = ALU_PASSB;
        alu_src   = 1'b1;
        reg_wr_en = 1'b1;
        imm_sel   = IMM_U;
      end
      OP_AUIPC: begin
        alu_a_pc  = 1'b1;
        alu_src   = 1'b1;
        reg_wr_en = 1'b1;
        imm_sel   = IMM_U;
      end
      OP_JAL: begin
        jump       = 1'b1;
        result_src = 2'd2;
        reg_wr_en  = 1'b1;
        imm_sel    = IMM_J;
      end
      OP_JALR: begin
        jalr       = 1'b1;
        result_src = 2'd2;
        alu_src    = 1'b1;
        reg_wr_en  = 1'b1;
        imm_sel    = IMM_I;
        illegal    = (funct3 != 3'd0);
      end
      OP_BRANCH: begin
        branch  = 1'b1;
        alu_op  = ALU_SUB;
        imm_sel = IMM_B;
        illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OP_LOAD: begin
        mem_rd_en  = 1'b1;
        result_src = 2'd1;
        alu_src    = 1'b1;
        reg_wr_en  = 1'b1;
        imm_sel    = IMM_I;
        illegal    = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OP_STORE: begin
        mem_wr_en = 1'b1;
        alu_src   = 1'b1;
        imm_sel   = IMM_S;
        illegal   = (funct3 > 3'd2);
      end
      OP_IMM: begin
        alu_src   = 1'b1;
        reg_wr_en = 1'b1;
        imm_sel   = IMM_I;
        case (funct3)
          3'd0: alu_op = ALU_ADD;
          3'd1: begin
            alu_op  = ALU_SLL;
            illegal = (funct7 != 7'h00);
          end
          3'd2: alu_op = ALU_SLT;
          3'd3: alu_op = ALU_SLTU;
          3'd4: alu_op = ALU_XOR;
          3'd5: begin
            alu_op  = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
          end
          3'd6: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OP_REG: begin
        reg_wr_en = 1'b1;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0: alu_op = ALU_ADD;
            3'd1: alu_op = ALU_SLL;
            3'd2: alu_op = ALU_SLT;
            3'd3: alu_op = ALU_SLTU;
            3'd4: alu_op = ALU_XOR;
            3'd5: alu_op = ALU_SRL;
            3'd6: alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
          alu_op = ALU_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
          alu_op = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase

    // An illegal instruction must not disturb architectural state downstream.
    if (illegal) begin
      alu_op     = ALU_ADD;
      alu_src    = 1'b0;
      alu_a_pc   = 1'b0;
      reg_wr_en  = 1'b0;
      mem_rd_en  = 1'b0;
      mem_wr_en  = 1'b0;
      result_src = 2'd0;
      branch     = 1'b0;
      jump       = 1'b0;
      jalr       = 1'b0;
    end
    if (rd_a == 5'd0) reg_wr_en = 1'b0;
  end

  logic [XLEN-1:0] imm;

  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I: imm = {{20{instr_dc_i[31]}}, instr_dc_i[31:20]};
      IMM_S: imm = {{20{instr_dc_i[31]}}, instr_dc_i[31:25], instr_dc_i[11:7]};
      IMM_B: imm = {{19{instr_dc_i[31]}}, instr_dc_i[31], instr_dc_i[7],
                    instr_dc_i[30:25], instr_dc_i[11:8], 1'b0};
      IMM_U: imm = {instr_dc_i[31:12], 12'h000};
      IMM_J: imm = {{11{instr_dc_i[31]}}, instr_dc_i[31], instr_dc_i[19:12],
                    instr_dc_i[20], instr_dc_i[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] rs1_rd;
  logic [XLEN-1:0] rs2_rd;

  always_ff @(posedge clk_i) begin
    if (rst_i && (CLEAR_REGS != 0)) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rd_wr_en_wb_i && (rd_a_wb_i != 5'd0)) begin
      regs_q[rd_a_wb_i] <= rd_wd_wb_i;
    end
  end

  // Same-cycle writeback bypasses the array so the operand is never stale.
  assign rs1_rd = (rs1_a == 5'd0) ? '0 :
                  (rd_wr_en_wb_i && rd_a_wb_i == rs1_a) ? rd_wd_wb_i : regs_q[rs1_a];
  assign rs2_rd = (rs2_a == 5'd0) ? '0 :
                  (rd_wr_en_wb_i && rd_a_wb_i == rs2_a) ? rd_wd_wb_i : regs_q[rs2_a];

  ex_t ex_d;
  ex_t ex_q;

  always_comb begin
    ex_d            = '0;
    ex_d.rs1_d      = rs1_rd;
    ex_d.rs2_d      = rs2_rd;
    ex_d.imm        = imm;
    ex_d.pc         = pc_dc_i;
    ex_d.pc4        = pc_next_4_dc_i;
    ex_d.rs1_a      = rs1_a;
    ex_d.rs2_a      = rs2_a;
    ex_d.rd_a       = rd_a;
    ex_d.funct3     = funct3;
    ex_d.alu_op     = alu_op;
    ex_d.alu_src    = alu_src;
    ex_d.alu_a_pc   = alu_a_pc;
    ex_d.reg_wr_en  = reg_wr_en;
    ex_d.mem_rd_en  = mem_rd_en;
    ex_d.mem_wr_en  = mem_wr_en;
    ex_d.result_src = result_src;
    ex_d.branch     = branch;
    ex_d.jump       = jump;
    ex_d.jalr       = jalr;
    ex_d.illegal    = illegal;
    // An all-zero word from fetch is a bubble, identical to a flush.
    if (instr_dc_i == 32'h0) ex_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_ex_i) ex_q <= '0;
    else if (!stall_dc_i)    ex_q <= ex_d;
  end

  assign rs1_d_ex_o      = ex_q.rs1_d;
  assign rs2_d_ex_o      = ex_q.rs2_d;
  assign imm_ex_o        = ex_q.imm;
  assign rs1_a_ex_o      = ex_q.rs1_a;
  assign rs2_a_ex_o      = ex_q.rs2_a;
  assign rd_a_ex_o       = ex_q.rd_a;
  assign funct3_ex_o     = ex_q.funct3;
  assign alu_op_ex_o     = ex_q.alu_op;
  assign alu_src_ex_o    = ex_q.alu_src;
  assign alu_a_pc_ex_o   = ex_q.alu_a_pc;
  assign reg_wr_en_ex_o  = ex_q.reg_wr_en;
  assign mem_rd_en_ex_o  = ex_q.mem_rd_en;
  assign mem_wr_en_ex_o  = ex_q.mem_wr_en;
  assign result_src_ex_o = ex_q.result_src;
  assign branch_ex_o     = ex_q.branch;
  assign jump_ex_o       = ex_q.jump;
  assign jalr_ex_o       = ex_q.jalr;
  assign illegal_ex_o    = ex_q.illegal;
  assign pc_ex_o         = ex_q.pc;
  assign pc_next_4_ex_o  = ex_q.pc4;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected pipeline entries are queued when an
// instruction is presented and compared one cycle later.
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_dc_i, pc_dc_i, pc_next_4_dc_i;
  logic        stall_dc_i, flush_ex_i, rd_wr_en_wb_i;
  logic [4:0]  rd_a_wb_i;
  logic [31:0] rd_wd_wb_i;
  logic [31:0] rs1_d_ex_o, rs2_d_ex_o, imm_ex_o, pc_ex_o, pc_next_4_ex_o;
  logic [4:0]  rs1_a_ex_o, rs2_a_ex_o, rd_a_ex_o;
  logic [2:0]  funct3_ex_o;
  logic [3:0]  alu_op_ex_o;
  logic        alu_src_ex_o, alu_a_pc_ex_o, reg_wr_en_ex_o, mem_rd_en_ex_o, mem_wr_en_ex_o;
  logic [1:0]  result_src_ex_o;
  logic        branch_ex_o, jump_ex_o, jalr_ex_o, illegal_ex_o;

  always #5 clk_i = ~clk_i;

  decode_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_dc_i(instr_dc_i), .pc_dc_i(pc_dc_i),
    .pc_next_4_dc_i(pc_next_4_dc_i), .stall_dc_i(stall_dc_i), .flush_ex_i(flush_ex_i),
    .rd_wr_en_wb_i(rd_wr_en_wb_i), .rd_a_wb_i(rd_a_wb_i), .rd_wd_wb_i(rd_wd_wb_i),
    .rs1_d_ex_o(rs1_d_ex_o), .rs2_d_ex_o(rs2_d_ex_o), .imm_ex_o(imm_ex_o),
    .rs1_a_ex_o(rs1_a_ex_o), .rs2_a_ex_o(rs2_a_ex_o), .rd_a_ex_o(rd_a_ex_o),
    .funct3_ex_o(funct3_ex_o), .alu_op_ex_o(alu_op_ex_o), .alu_src_ex_o(alu_src_ex_o),
    .alu_a_pc_ex_o(alu_a_pc_ex_o), .reg_wr_en_ex_o(reg_wr_en_ex_o),
    .mem_rd_en_ex_o(mem_rd_en_ex_o), .mem_wr_en_ex_o(mem_wr_en_ex_o),
    .result_src_ex_o(result_src_ex_o), .branch_ex_o(branch_ex_o), .jump_ex_o(jump_ex_o),
    .jalr_ex_o(jalr_ex_o), .illegal_ex_o(illegal_ex_o), .pc_ex_o(pc_ex_o),
    .pc_next_4_ex_o(pc_next_4_ex_o)
  );

  typedef struct {
    logic [31:0] rs1, rs2, imm, pc, pc4;
    logic [17:0] addr;
    logic [14:0] ctrl;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] model [32];
  logic [31:0] pc_v;
  int          errors = 0;
  int          checks = 0;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SRA = 4'd7, PASSB = 4'd10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {alu_op, alu_src, alu_a_pc, reg_wr, mem_rd, mem_wr, result_src, branch, jump, jalr, illegal}
  function automatic logic [14:0] ctl(input logic [3:0] op, input logic src, input logic apc,
                                      input logic wr, input logic mr, input logic mw,
                                      input logic [1:0] rs, input logic br, input logic jp,
                                      input logic jr, input logic il);
    return {op, src, apc, wr, mr, mw, rs, br, jp, jr, il};
  endfunction

  function automatic logic [31:0] rdval(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (rd_wr_en_wb_i && rd_a_wb_i == a) return rd_wd_wb_i;
    return model[a];
  endfunction

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk_i);
    if (rst_i) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (rd_wr_en_wb_i && rd_a_wb_i != 5'd0) begin
      model[rd_a_wb_i] = rd_wd_wb_i;
    end
    #1;
    e   = q.pop_front();
    cur = e;
    chk({tag, ".rs1_d"}, rs1_d_ex_o, e.rs1);
    chk({tag, ".rs2_d"}, rs2_d_ex_o, e.rs2);
    chk({tag, ".imm"}, imm_ex_o, e.imm);
    chk({tag, ".pc"}, pc_ex_o, e.pc);
    chk({tag, ".pc4"}, pc_next_4_ex_o, e.pc4);
    chk({tag, ".addr"}, 32'({rs1_a_ex_o, rs2_a_ex_o, rd_a_ex_o, funct3_ex_o}), 32'(e.addr));
    chk({tag, ".ctrl"}, 32'({alu_op_ex_o, alu_src_ex_o, alu_a_pc_ex_o, reg_wr_en_ex_o,
                             mem_rd_en_ex_o, mem_wr_en_ex_o, result_src_ex_o, branch_ex_o,
                             jump_ex_o, jalr_ex_o, illegal_ex_o}), 32'(e.ctrl));
  endtask

  task automatic wb(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    rd_wr_en_wb_i = we;
    rd_a_wb_i     = wa;
    rd_wd_wb_i    = wd;
  endtask

  task automatic issue(input string tag, input logic [31:0] instr, input logic [14:0] ctrl,
                       input logic [31:0] imm);
    exp_t e;
    instr_dc_i     = instr;
    pc_dc_i        = pc_v;
    pc_next_4_dc_i = pc_v + 32'd4;
    e.rs1  = rdval(instr[19:15]);
    e.rs2  = rdval(instr[24:20]);
    e.imm  = imm;
    e.pc   = pc_v;
    e.pc4  = pc_v + 32'd4;
    e.addr = {instr[19:15], instr[24:20], instr[11:7], instr[14:12]};
    e.ctrl = ctrl;
    q.push_back(e);
    pc_v += 32'd4;
    step(tag);
  endtask

  task automatic bubble(input string tag, input logic [31:0] instr, input logic fl,
                        input logic rs, input logic st);
    exp_t e;
    e = '{default: '0};
    instr_dc_i = instr;
    pc_dc_i    = pc_v;
    pc_next_4_dc_i = pc_v + 32'd4;
    flush_ex_i = fl;
    rst_i      = rs;
    stall_dc_i = st;
    q.push_back(e);
    step(tag);
    flush_ex_i = 1'b0;
    rst_i      = 1'b0;
    stall_dc_i = 1'b0;
  endtask

  task automatic hold(input string tag, input logic [31:0] instr);
    stall_dc_i     = 1'b1;
    instr_dc_i     = instr;
    pc_dc_i        = pc_v + 32'h100;
    pc_next_4_dc_i = pc_v + 32'h104;
    q.push_back(cur);
    step(tag);
    stall_dc_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; stall_dc_i = 1'b0; flush_ex_i = 1'b0;
    instr_dc_i = 32'h0; pc_dc_i = 32'h0; pc_next_4_dc_i = 32'h0;
    wb(1'b0, 5'd0, 32'h0);
    pc_v = 32'h0000_1000;
    for (int i = 0; i < 32; i++) model[i] = 32'hXXXX_XXXX;

    wb(1'b1, 5'd5, 32'h55);
    bubble("reset", 32'hFFF28313, 1'b0, 1'b1, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    issue("x5_after_rst", 32'hFFF28313, ctl(ADD,1,0,1,0,0,2'd0,0,0,0,0), 32'hFFFF_FFFF);

    wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    bubble("fetch_bubble_a", 32'h0, 1'b0, 1'b0, 1'b0);
    wb(1'b1, 5'd1, 32'h1111_1111);
    bubble("fetch_bubble_b", 32'h0, 1'b0, 1'b0, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    issue("addi", 32'hFFF28313, ctl(ADD,1,0,1,0,0,2'd0,0,0,0,0), 32'hFFFF_FFFF);

    wb(1'b1, 5'd7, 32'h0000_1234);
    issue("add_bypass", 32'h0003_8433, ctl(ADD,0,0,1,0,0,2'd0,0,0,0,0), 32'h0);

    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    issue("addi_x0_wr", 32'h0010_0013, ctl(ADD,1,0,0,0,0,2'd0,0,0,0,0), 32'h1);
    wb(1'b0, 5'd0, 32'h0);
    issue("addi_x0_rd", 32'h0010_0013, ctl(ADD,1,0,0,0,0,2'd0,0,0,0,0), 32'h1);

    wb(1'b1, 5'd2, 32'h2222_2222);
    issue("beq", 32'hFE20_8CE3, ctl(SUB,0,0,0,0,0,2'd0,1,0,0,0), 32'hFFFF_FFF8);
    wb(1'b0, 5'd0, 32'h0);
    bubble("flush", 32'h0040_A603, 1'b1, 1'b0, 1'b0);

    issue("lw",    32'h0040_A603, ctl(ADD,1,0,1,1,0,2'd1,0,0,0,0), 32'h4);
    issue("sw",    32'h0020_A423, ctl(ADD,1,0,0,0,1,2'd0,0,0,0,0), 32'h8);
    issue("jal",   32'h0100_00EF, ctl(ADD,0,0,1,0,0,2'd2,0,1,0,0), 32'h10);
    issue("srai",  32'h4030_D693, ctl(SRA,1,0,1,0,0,2'd0,0,0,0,0), 32'h403);
    issue("auipc", 32'h0000_1717, ctl(ADD,1,1,1,0,0,2'd0,0,0,0,0), 32'h1000);
    issue("mul_illegal", 32'h0210_84B3, ctl(ADD,0,0,0,0,0,2'd0,0,0,0,1), 32'h0);

    issue("lui", 32'h1234_5537, ctl(PASSB,1,0,1,0,0,2'd0,0,0,0,0), 32'h1234_5000);
    wb(1'b1, 5'd3, 32'h0000_CAFE);
    hold("stall1", 32'h0031_84B3);
    wb(1'b0, 5'd0, 32'h0);
    hold("stall2", 32'h0010_0013);
    hold("stall3", 32'h0);
    issue("add_x3", 32'h0031_84B3, ctl(ADD,0,0,1,0,0,2'd0,0,0,0,0), 32'h0);

    bubble("fetch_bubble_c", 32'h0, 1'b0, 1'b0, 1'b0);
    issue("add_x3_again", 32'h0031_84B3, ctl(ADD,0,0,1,0,0,2'd0,0,0,0,0), 32'h0);
    bubble("flush_over_stall", 32'h0031_84B3, 1'b1, 1'b0, 1'b1);
    issue("add_x3_post", 32'h0031_84B3, ctl(ADD,0,0,1,0,0,2'd0,0,0,0,0), 32'h0);
    bubble("rst_over_stall", 32'h0031_84B3, 1'b0, 1'b1, 1'b1);
    issue("x3_cleared", 32'h0031_84B3, ctl(ADD,0,0,1,0,0,2'd0,0,0,0,0), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
